// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
//   Barrel shifter/rotator split into SW = clog2(WIDTH) registered stages.
//   Stage k applies a 2^k step when bit k of the requested amount is set.
//   Each stage forwards the request's mode bits and the operand's original
//   sign bit, so arithmetic fill always uses din[WIDTH-1] as it was when
//   the request was accepted. Valid/ready handshake on both sides.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid        request present on din/shift_value/select/direction/arith
//   in_ready        request accepted this cycle (pipeline advancing, not in reset)
//   select          0 = shift, 1 = rotate
//   direction       0 = right, 1 = left
//   arith           sign-fill on right shift (ignored for rotate / left)
//   shift_value     amount, 0..WIDTH-1
//   din             operand
//   out_valid       dout/zero hold a completed result
//   out_ready       downstream accepts the result
//   dout            result
//   zero            dout == 0 while out_valid
module pipelined_barrel_shifter #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             select,
  input  logic             direction,
  input  logic             arith,
  input  logic [SW-1:0]    shift_value,
  input  logic [WIDTH-1:0] din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             zero
);

  // Per-request control carried alongside the data.
  typedef struct packed {
    logic [SW-1:0] amt;   // full shift amount; stage k consumes bit k
    logic          rot;   // rotate instead of shift
    logic          left;  // left instead of right
    logic          ari;   // arithmetic right shift requested
    logic          sign;  // din[WIDTH-1] captured at acceptance
  } side_t;

  // One fixed-distance step. Rotate wraps; left shifts zero-fill;
  // right shifts fill with 'fill' replicated into the vacated MSBs.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] data,
    input int unsigned      amt,
    input logic             rot,
    input logic             left,
    input logic             fill
  );
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] res;
    ones = '1;
    if (rot) begin
      res = left ? ((data << amt) | (data >> (WIDTH - amt)))
                 : ((data >> amt) | (data << (WIDTH - amt)));
    end else if (left) begin
      res = data << amt;
    end else if (fill) begin
      res = (data >> amt) | ~(ones >> amt);
    end else begin
      res = data >> amt;
    end
    return res;
  endfunction

  logic             advance;
  logic             src_valid [SW];
  logic [WIDTH-1:0] src_data  [SW];
  side_t            src_side  [SW];
  logic             stg_valid [SW];
  logic [WIDTH-1:0] stg_data  [SW];
  side_t            stg_side  [SW-1];

  assign out_valid = stg_valid[SW-1];
  assign dout      = stg_data[SW-1];
  assign zero      = out_valid & (dout == '0);

  // Whole pipeline moves together; it only stops when a finished result
  // is waiting and downstream is not taking it.
  assign advance   = !out_valid | out_ready;
  // Reset holds out_valid low, which would otherwise make advance 1;
  // gate with rst_n so nothing is offered as accepted during reset.
  assign in_ready  = rst_n & advance;

  assign src_valid[0] = in_valid;
  assign src_data[0]  = din;
  assign src_side[0]  = '{amt:  shift_value,
                          rot:  select,
                          left: direction,
                          ari:  arith,
                          sign: din[WIDTH-1]};

  for (genvar k = 1; k < SW; k++) begin : g_link
    assign src_valid[k] = stg_valid[k-1];
    assign src_data[k]  = stg_data[k-1];
    assign src_side[k]  = stg_side[k-1];
  end

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int unsigned STEP = 1 << k;

    logic [WIDTH-1:0] nxt_data;

    assign nxt_data = src_side[k].amt[k]
                    ? shift_step(src_data[k], STEP, src_side[k].rot, src_side[k].left,
                                 src_side[k].ari & src_side[k].sign)
                    : src_data[k];

    // Data only loads with a valid request, so the output register keeps
    // the last valid result while bubbles pass through.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg_valid[k] <= 1'b0;
        stg_data[k]  <= '0;
      end else if (advance) begin
        stg_valid[k] <= src_valid[k];
        if (src_valid[k]) begin
          stg_data[k] <= nxt_data;
        end
      end
    end

    // The final stage needs no control, only its data.
    if (k < SW - 1) begin : g_side
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg_side[k] <= '0;
        end else if (advance && src_valid[k]) begin
          stg_side[k] <= src_side[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH = 8, three stages).
module tb_pipelined_barrel_shifter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       select = 1'b0;
  logic       direction = 1'b0;
  logic       arith = 1'b0;
  logic [2:0] shift_value = '0;
  logic [7:0] din = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] dout;
  logic       zero;

  int   passed = 0;
  int   total = 0;
  int   cyc = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  logic [7:0] sb [$];
  bit   acc_hist [8192];
  bit   ov_hist  [8192];
  bit   stalled = 1'b0;

  pipelined_barrel_shifter #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .select      (select),
    .direction   (direction),
    .arith       (arith),
    .shift_value (shift_value),
    .din         (din),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dout        (dout),
    .zero        (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic note_fail(input string name);
    total++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Whole-word reference: rotate via a doubled operand, shifts via
  // Verilog's own logical and arithmetic shift operators.
  function automatic logic [7:0] model(input logic sel, input logic dir, input logic ari,
                                       input logic [2:0] sv, input logic [7:0] x);
    logic [15:0] dd;
    logic [15:0] t;
    logic [7:0]  r;
    dd = {x, x};
    if (sel) begin
      if (dir) begin t = dd << sv; r = t[15:8]; end
      else     begin t = dd >> sv; r = t[7:0];  end
    end else if (dir) begin
      r = x << sv;
    end else if (ari) begin
      r = $signed(x) >>> sv;
    end else begin
      r = x >> sv;
    end
    return r;
  endfunction

  task automatic send(input logic s, input logic d, input logic a,
                      input logic [2:0] sv, input logic [7:0] x);
    int tries = 0;
    @(negedge clk);
    in_valid = 1'b1; select = s; direction = d; arith = a; shift_value = sv; din = x;
    #1;
    while (!in_ready && tries < 100) begin
      @(negedge clk);
      #1;
      tries++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      note_fail("accept_timeout");
    end else begin
      sb.push_back(model(s, d, a, sv, x));
      if (cyc < 8192) acc_hist[cyc] = 1'b1;
      @(posedge clk);
    end
  endtask

  task automatic send_rand();
    send(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: every presented result must match the scoreboard head,
  // including on stalled cycles (so dout may not change while held).
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (cyc < 8192) ov_hist[cyc] = out_valid;
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (stalled) chk("valid_held", 32'(out_valid), 32'd1);
        if (out_valid) begin
          if (sb.size() == 0) begin
            note_fail("spurious_result");
          end else begin
            chk("dout", 32'(dout), 32'(sb[0]));
            chk("zero", 32'(zero), 32'(sb[0] == 8'd0));
            if (out_ready) void'(sb.pop_front());
          end
          stalled = !out_ready;
        end else begin
          chk("zero_idle", 32'(zero), 32'd0);
          stalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog_timeout (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    int seen;

    // Reset state
    rst_n = 1'b0;
    rdy_mode = 0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // Directed cases
    send(1'b0, 1'b0, 1'b0, 3'd3, 8'b1001_0110);
    send(1'b0, 1'b0, 1'b1, 3'd3, 8'b1001_0110);
    send(1'b1, 1'b0, 1'b0, 3'd3, 8'b1001_0110);
    send(1'b1, 1'b1, 1'b0, 3'd1, 8'b1000_0001);
    send(1'b0, 1'b1, 1'b0, 3'd7, 8'b0000_0001);
    send(1'b0, 1'b1, 1'b1, 3'd2, 8'b1000_0001);
    for (int m = 0; m < 8; m++) send(m[0], m[1], m[2], 3'd0, 8'b1011_0101);
    send(1'b0, 1'b0, 1'b0, 3'd4, 8'b0000_1111);
    send(1'b0, 1'b0, 1'b1, 3'd7, 8'b1000_0000);
    idle(1);
    drain();

    // Bubbles: result pattern must equal acceptance pattern three cycles later
    idle(4);
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) send_rand();
      else idle(1);
    end
    idle(6);
    for (int c = c0; c < c0 + 10; c++)
      chk($sformatf("bubble_c%0d", c - c0), 32'(ov_hist[c + 3]), 32'(acc_hist[c]));
    drain();

    // Backpressure: eight back-to-back requests with a five-cycle stall
    fork
      for (int i = 0; i < 8; i++) send_rand();
      begin
        repeat (4) @(negedge clk);
        rdy_mode = 2;
        repeat (5) begin
          @(negedge clk);
          #3;
          chk("stall_in_ready", 32'(in_ready), 32'd0);
        end
        rdy_mode = 0;
      end
    join
    idle(1);
    drain();

    // Random traffic with random downstream readiness
    rdy_mode = 1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      else send_rand();
    end
    idle(1);
    rdy_mode = 0;
    drain();

    // Reset with three requests in flight
    idle(4);
    send_rand();
    send_rand();
    send_rand();
    #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_zero", 32'(zero), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      #2;
      if (out_valid) seen++;
    end
    chk("no_result_after_reset", 32'(seen), 32'd0);
    send(1'b1, 1'b1, 1'b0, 3'd5, 8'b1100_0011);
    idle(1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits; power of two, >= 4.
REQ-002 SHALL have derived parameter SW = clog2(WIDTH), width of shift_value and pipeline depth; not user-overridable.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  request present on din/shift_value/select/direction/arith.
REQ-006 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-007 SHALL have port select  input  1  0 = shift, 1 = rotate.
REQ-008 SHALL have port direction  input  1  0 = right, 1 = left.
REQ-009 SHALL have port arith  input  1  1 = arithmetic (sign-fill) on right shift; ignored when select=1 or direction=1.
REQ-010 SHALL have port shift_value  input  SW  shift/rotate amount, 0..WIDTH-1.
REQ-011 SHALL have port din  input  WIDTH  operand.
REQ-012 SHALL have port out_valid  output  1  dout/zero hold a completed result.
REQ-013 SHALL have port out_ready  input  1  downstream accepts result.
REQ-014 SHALL have port dout  output  WIDTH  result.
REQ-015 SHALL have port zero  output  1  high when dout == 0 and out_valid = 1; 0 otherwise.

Function
REQ-016 SHALL implement SW registered stages; stage k shifts/rotates by 2^k when shift_value bit k is set, else passes through; stage 0 handles LSB.
REQ-017 Each stage SHALL carry valid, data, remaining amount bits, select, direction, arith, and the sign bit captured from din at acceptance.
REQ-018 Latency SHALL be exactly SW cycles from accepted request (in_valid & in_ready) to out_valid, absent stalls.
REQ-019 Logical right shift SHALL zero-fill MSBs; left shift SHALL zero-fill LSBs regardless of arith.
REQ-020 Arithmetic right shift SHALL fill MSBs with original din[WIDTH-1] at every stage.
REQ-021 Rotate SHALL wrap bits end-to-end with no fill; direction selects ROR/ROL.
REQ-022 shift_value = 0 SHALL return din unchanged in every mode.
REQ-023 Pipeline SHALL advance when advance = !out_valid | out_ready; in_ready SHALL equal advance (combinational).
REQ-024 When advance = 0, all stage registers, dout, out_valid SHALL hold; inputs SHALL be ignored.
REQ-025 Bubbles (in_valid=0 while advance=1) SHALL propagate as invalid stages; result throughput SHALL be one per cycle under continuous valid/ready.
REQ-026 out_valid SHALL stay high with dout stable until out_ready sampled high (no drop, no change while stalled).
REQ-027 Results SHALL emerge in acceptance order; no request dropped or duplicated.
REQ-028 Data registers of invalid stages SHALL NOT be required to hold any value; dout SHALL reflect only the last valid result.

Reset
REQ-029 rst_n low SHALL immediately clear all stage valid bits and data to 0: out_valid=0, dout=0, zero=0.
REQ-030 While rst_n low, in_ready SHALL be 0; after release, in_ready SHALL be 1 (pipeline empty).
REQ-031 Reset mid-operation SHALL discard all in-flight requests; none SHALL appear after release.
REQ-032 Release SHALL be synchronised to clk externally; first acceptance on first rising edge with rst_n high.

Verification (WIDTH=8, latency 3)
REQ-033 Logical: select=0,dir=0,arith=0,sv=3,din=1001_0110 -> dout=0001_0010 after 3 cycles; arith=1 same -> 1111_0010.
REQ-034 Rotate/left: select=1,dir=0,sv=3,din=1001_0110 -> 1101_0010; select=1,dir=1,sv=1,din=1000_0001 -> 0000_0011; select=0,dir=1,sv=7,din=0000_0001 -> 1000_0000; arith=1,dir=1,sv=2,din=1000_0001 -> 0000_0100.
REQ-035 Boundary: sv=0 every mode, din=1011_0101 -> 1011_0101; select=0,dir=0,sv=4,din=0000_1111 -> 0000_0000 with zero=1.
REQ-036 Backpressure: stream 8 back-to-back requests, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0, dout stable during stall, all 8 results in order, none lost.
REQ-037 Throughput/bubbles: alternate in_valid 1/0 with out_ready=1 -> out_valid alternates 1/0 delayed 3 cycles.
REQ-038 Reset: assert rst_n=0 with 3 requests in flight -> out_valid=0, dout=0 immediately, no result after release, in_ready=1 on first post-release cycle.
